// File: rtl/calc_pkg.sv
// Shared definitions for the keypad front end of the calculator:
// key-code constants, scanner state encoding and keypad helpers.
package calc_pkg;

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_NONE  = 4'd14;
  localparam logic [3:0] KEY_CLEAR = 4'd15;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    EMIT      = 2'd2,
    WAIT_REL  = 2'd3
  } scan_state_e;

  // Physical key position (row, col) to calculator key code.
  // Unused pad positions map to KEY_NONE and are never emitted.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_ADD;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_SUB;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_MUL;
      4'd12:   code = KEY_CLEAR;
      4'd13:   code = 4'd0;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  // Index of the lowest-numbered active-low row; 0 when none is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else if (!rows[3]) begin
      idx = 2'd3;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

  // One-hot active-low column drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the key-code output toward the calculator FSM.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       key_valid;

  modport master (
    input  row_n,
    output col_n,
    output key,
    output key_valid
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key,
    input  key_valid
  );
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Generic N-bit two-flop synchroniser with a configurable reset value.
module row_sync #(
  parameter int          N       = 4,
  parameter logic [N-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta_d, meta_q;
  logic [N-1:0] sync_d, sync_q;

  // Next-state of the two synchroniser stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops with synchronous reset to the idle pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column scan, press/release
// debounce and single-cycle key-code emission for the calculator FSM.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CW      = $clog2(MAX_CNT);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  logic [3:0]  rows_s;
  logic        row_bit_s;
  logic [3:0]  emit_code_s;

  scan_state_e state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [1:0]  col_idx_d, col_idx_q;
  logic [1:0]  row_idx_d, row_idx_q;
  logic [3:0]  col_n_d, col_n_q;
  logic [3:0]  key_d, key_q;
  logic        key_valid_d, key_valid_q;

  row_sync #(
    .N       (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.row_n),
    .q   (rows_s)
  );

  assign row_bit_s   = rows_s[row_idx_q];
  assign emit_code_s = keymap(row_idx_q, col_idx_q);

  // Scan / debounce / emit sequencing and registered output next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    col_n_d     = col_n_q;
    key_d       = KEY_NONE;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = CNT_ZERO;
          if (rows_s != 4'hF) begin
            // Freeze on this column; remember which row went low.
            row_idx_d = lowest_low(rows_s);
            state_d   = DEB_PRESS;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            col_n_d   = col_drive(col_idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DEB_PRESS: begin
        if (!row_bit_s) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = EMIT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Glitch: resume scanning the same column from a fresh dwell.
          cnt_d   = CNT_ZERO;
          state_d = SCAN;
        end
      end
      EMIT: begin
        if (emit_code_s != KEY_NONE) begin
          key_d       = emit_code_s;
          key_valid_d = 1'b1;
        end else begin
          key_d       = KEY_NONE;
          key_valid_d = 1'b0;
        end
        cnt_d   = CNT_ZERO;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (row_bit_s) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d     = CNT_ZERO;
            col_idx_d = col_idx_q + 2'd1;
            col_n_d   = col_drive(col_idx_q + 2'd1);
            state_d   = SCAN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Any low sample restarts the release window (bounce).
          cnt_d = CNT_ZERO;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = SCAN;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      cnt_q       <= CNT_ZERO;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      key_q       <= KEY_NONE;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      col_n_q     <= col_n_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the row lines, and maps each press to a calculator key code.
- Emits each accepted press as a single-cycle key code on `key`; between presses `key` holds the idle code 14.
- Sits directly upstream of the calculator control FSM, which treats 0-9 as digits, 10-12 as operations, 15 as clear, and 13/14 as no key.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled (>=4).
- DEBOUNCE, 20000: consecutive stable cycles needed to accept a press or a release (>=2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- row_n  input  4  keypad rows, active-low, asynchronous to clk
- col_n  output  4  column drive, one-hot active-low
- key  output  4  key code; idle value 14
- key_valid  output  1  high for exactly the one cycle in which `key` carries a press code

Behaviour:
- Reset values (on the clk edge where rst=1): col_n=4'b1110, key=4'd14, key_valid=0, state=SCAN, column index 0, all counters 0, synchroniser flops 4'hF.
- rst has priority over everything, including mid-debounce and EMIT; no pulse is issued after reset.
- Input path:
  - row_n passes through a 2-flop synchroniser to give rows_s.
  - Latency is 2 cycles; all decisions use rows_s only.
- Keymap, index = row*4+col:
  - row0: 1, 2, 3, 10
  - row1: 4, 5, 6, 11
  - row2: 7, 8, 9, 12
  - row3: 15, 0, NONE, NONE
  - NONE positions are debounced as normal but never emitted.
- Multiple rows low at the sample point: the lowest-numbered low row wins.
- Only the driven column is seen, so two keys in different columns are handled in scan order.
- State SCAN:
  - Dwell counter counts 0..SCAN_DIV-1 with the current column driven.
  - At count SCAN_DIV-1 with rows_s != 4'hF: latch row index and column, clear the counter, go to DEB_PRESS. The column stays driven.
  - At count SCAN_DIV-1 with rows_s == 4'hF: advance the column (0->1->2->3->0) and restart the dwell.
- State DEB_PRESS:
  - While the latched row bit is low, increment the counter.
  - If the bit goes high, clear the counter, return to SCAN on the same column with dwell restarted, and emit nothing.
  - When the counter reaches DEBOUNCE-1 with the bit still low, go to EMIT.
- State EMIT (one cycle):
  - If the mapped code is not NONE, register key=code and key_valid=1. Both are visible for the one cycle following the EMIT cycle, then key=14 and key_valid=0.
  - Go to WAIT_REL.
- State WAIT_REL:
  - The counter increments while the latched row bit is high and resets to 0 on any low sample.
  - When it reaches DEBOUNCE-1, advance the column, restart the dwell, and go to SCAN.
  - No auto-repeat: a held key produces exactly one pulse.
- Release bounce shorter than DEBOUNCE causes neither a release nor a second press.
- Counter widths are $clog2(max(SCAN_DIV,DEBOUNCE)).
- key and key_valid are registered outputs; col_n is registered and changes only in SCAN.

Decomposition:
- Package calc_pkg:
  - Key-code constants KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_NONE=14, KEY_CLEAR=15.
  - State enum for this block.
  - Keymap function (row, col) -> 4-bit code.
- One sub-module: row_sync, a generic N-bit 2-flop synchroniser with a reset value parameter, instantiated at N=4 with reset value 4'hF.

Test Plan (SCAN_DIV=4, DEBOUNCE=8):
- Reset, no press, 32 cycles -> col_n steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; key=14 and key_valid=0 throughout.
- Hold row1/col2 (row_n=4'b1101 while col_n=4'b1011) for 60 cycles -> exactly one cycle with key=6 and key_valid=1; scan stays frozen until release plus 8 stable cycles, then resumes at col 3.
- Row0/col0 pulsed low for 3 cycles only -> no pulse; scan resumes on col 0 with dwell restarted.
- Press row3/col0 -> a single key=15 pulse. Press row3/col3 -> no pulse, and scan resumes after release debounce.
- Rows 0 and 2 low together on col 0 -> a single key=1 pulse. Release bouncing low for 5 cycles then high -> no second pulse.
- Assert rst during DEB_PRESS at counter 5 -> next cycle col_n=1110, key=14, key_valid=0, state SCAN; no pulse is ever emitted for that press.
